thr_load_ctrl: RTL and testbench

- Transmit-holding-register (THR) load controller for the UART transmit path.
- Arbitrates between two 8-bit write requesters: port 0 (CPU bus write) and port 1 (loopback/test pattern source).
- Sequences the load of the external 8-bit loadable THR register (load/D/Q style), then hands the byte to the transmit shift register (TSR) when the transmitter reports ready.
- Sits between the bus/test sources and the THR/TSR datapath; the THR register and the TSR are separate instances that it drives.

---
 rtl/uart_pkg.sv | 16 +
 rtl/thr_load_ctrl_rr_arb2.sv | 21 ++
 rtl/thr_load_ctrl.sv | 118 +++++++++++
 tb/tb_thr_load_ctrl.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART transmit-path definitions: THR load controller state encoding and data width.
package uart_pkg;

  localparam int UART_DATA_W = 8;

  localparam logic [1:0] ST_EMPTY  = 2'd0;
  localparam logic [1:0] ST_LOADED = 2'd1;
  localparam logic [1:0] ST_XFER   = 2'd2;

  typedef enum logic [1:0] {
    EMPTY  = ST_EMPTY,
    LOADED = ST_LOADED,
    XFER   = ST_XFER
  } thr_state_e;

endpackage

// File: rtl/thr_load_ctrl_rr_arb2.sv
// Two-way round-robin arbiter; ptr names the port that wins a tie, next_ptr names the loser.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] gnt,
  output logic       next_ptr
);

  always_comb begin
    gnt      = 2'b00;
    next_ptr = ptr;
    if (req[0] && (!req[1] || !ptr)) begin
      gnt      = 2'b01;
      next_ptr = 1'b1;
    end else if (req[1]) begin
      gnt      = 2'b10;
      next_ptr = 1'b0;
    end
  end

endmodule

// File: rtl/thr_load_ctrl.sv
// THR load controller: grants one of two byte writers, loads the THR, then hands the byte to the TSR.
module thr_load_ctrl
  import uart_pkg::*;
#(
  parameter int DATA_W = UART_DATA_W,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic [DATA_W-1:0] d0,
  output logic              ack0,
  input  logic              req1,
  input  logic [DATA_W-1:0] d1,
  output logic              ack1,
  output logic              thr_load,
  output logic [DATA_W-1:0] thr_d,
  output logic              thr_full,
  input  logic              tx_rdy,
  output logic              tsr_load,
  output logic [CNT_W-1:0]  xfer_cnt
);

  thr_state_e        state_q, state_d;
  logic              rr_ptr_q, rr_ptr_d;
  logic              ack0_q, ack0_d;
  logic              ack1_q, ack1_d;
  logic              thr_load_q, thr_load_d;
  logic [DATA_W-1:0] thr_d_q, thr_d_d;
  logic              thr_full_q, thr_full_d;
  logic              tsr_load_q, tsr_load_d;
  logic [CNT_W-1:0]  xfer_cnt_q, xfer_cnt_d;

  logic [1:0]        gnt;
  logic              next_ptr;

  rr_arb2 u_arb (
    .req      ({req1, req0}),
    .ptr      (rr_ptr_q),
    .gnt      (gnt),
    .next_ptr (next_ptr)
  );

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    ack0_d     = 1'b0;
    ack1_d     = 1'b0;
    thr_load_d = 1'b0;
    thr_d_d    = thr_d_q;
    thr_full_d = thr_full_q;
    tsr_load_d = 1'b0;
    xfer_cnt_d = xfer_cnt_q;
    case (state_q)
      EMPTY: begin
        thr_full_d = 1'b0;
        if (|gnt) begin
          ack0_d     = gnt[0];
          ack1_d     = gnt[1];
          thr_load_d = 1'b1;
          thr_d_d    = gnt[1] ? d1 : d0;
          rr_ptr_d   = next_ptr;
          state_d    = LOADED;
        end
      end
      LOADED: begin
        thr_full_d = 1'b1;
        // The THR is still capturing during the load-strobe cycle, so tx_rdy waits one edge.
        if (tx_rdy && !thr_load_q) begin
          tsr_load_d = 1'b1;
          state_d    = XFER;
        end
      end
      XFER: begin
        thr_full_d = 1'b0;
        xfer_cnt_d = xfer_cnt_q + CNT_W'(1);
        state_d    = EMPTY;
      end
      default: begin
        thr_full_d = 1'b0;
        state_d    = EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= EMPTY;
      rr_ptr_q   <= 1'b0;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      thr_load_q <= 1'b0;
      thr_d_q    <= '0;
      thr_full_q <= 1'b0;
      tsr_load_q <= 1'b0;
      xfer_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      ack0_q     <= ack0_d;
      ack1_q     <= ack1_d;
      thr_load_q <= thr_load_d;
      thr_d_q    <= thr_d_d;
      thr_full_q <= thr_full_d;
      tsr_load_q <= tsr_load_d;
      xfer_cnt_q <= xfer_cnt_d;
    end
  end

  assign ack0     = ack0_q;
  assign ack1     = ack1_q;
  assign thr_load = thr_load_q;
  assign thr_d    = thr_d_q;
  assign thr_full = thr_full_q;
  assign tsr_load = tsr_load_q;
  assign xfer_cnt = xfer_cnt_q;

endmodule

// File: tb/tb_thr_load_ctrl.sv
// Directed bench for thr_load_ctrl: reset, single write, contention, stall, counter wrap, reset in XFER.
module tb_thr_load_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req0 = 1'b0, req1 = 1'b0, tx_rdy = 1'b0;
  logic [7:0] d0 = 8'h00, d1 = 8'h00;
  logic       ack0, ack1, thr_load, thr_full, tsr_load;
  logic [7:0] thr_d, xfer_cnt;

  int total = 0;
  int bad   = 0;

  thr_load_ctrl #(.DATA_W(8), .CNT_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .req0     (req0),
    .d0       (d0),
    .ack0     (ack0),
    .req1     (req1),
    .d1       (d1),
    .ack1     (ack1),
    .thr_load (thr_load),
    .thr_d    (thr_d),
    .thr_full (thr_full),
    .tx_rdy   (tx_rdy),
    .tsr_load (tsr_load),
    .xfer_cnt (xfer_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req0 = 1'b0; req1 = 1'b0; tx_rdy = 1'b0;
    rst = 1'b1;
    #2;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    req0 = 1'b0; req1 = 1'b0; tx_rdy = 1'b0;
    #1 rst = 1'b1;
    tick();
    total++;
    if ({ack0, ack1, thr_load, thr_full, tsr_load} !== 5'b0 || thr_d !== 8'h00 || xfer_cnt !== 8'h00) begin
      bad++; $display("FAIL reset_state got=%b/%h/%h exp=00000/00/00",
                      {ack0, ack1, thr_load, thr_full, tsr_load}, thr_d, xfer_cnt);
    end
    rst = 1'b0;
    // load a byte and hit reset while LOADED with thr_full=1
    req0 = 1'b1; d0 = 8'h3C;
    tick();
    req0 = 1'b0;
    tick();
    total++;
    if (thr_full !== 1'b1) begin bad++; $display("FAIL reset_pre_full got=%b exp=1", thr_full); end
    #1 rst = 1'b1;
    #1;
    total++;
    if ({ack0, ack1, thr_load, thr_full, tsr_load} !== 5'b0 || thr_d !== 8'h00 || xfer_cnt !== 8'h00) begin
      bad++; $display("FAIL reset_async got=%b/%h/%h exp=00000/00/00",
                      {ack0, ack1, thr_load, thr_full, tsr_load}, thr_d, xfer_cnt);
    end
    tick();
    rst = 1'b0;
    req0 = 1'b1; d0 = 8'h5A;
    tick();
    total++;
    if (ack0 !== 1'b1 || thr_load !== 1'b1 || thr_d !== 8'h5A) begin
      bad++; $display("FAIL reset_regrant got=%b%b/%h exp=11/5a", ack0, thr_load, thr_d);
    end
    req0 = 1'b0; tx_rdy = 1'b1;
    tick(); tick(); tick();
    tx_rdy = 1'b0;
    total++;
    if (xfer_cnt !== 8'h01 || thr_full !== 1'b0) begin
      bad++; $display("FAIL reset_drain got=%h/%b exp=01/0", xfer_cnt, thr_full);
    end
  endtask

  task automatic test_single();
    do_reset();
    // tx_rdy in EMPTY must be ignored
    tx_rdy = 1'b1;
    tick(); tick(); tick();
    total++;
    if (tsr_load !== 1'b0 || thr_full !== 1'b0 || xfer_cnt !== 8'h00) begin
      bad++; $display("FAIL empty_txrdy got=%b%b/%h exp=00/00", tsr_load, thr_full, xfer_cnt);
    end
    tx_rdy = 1'b0;
    req0 = 1'b1; d0 = 8'hA5;
    tick();
    total++;
    if (ack0 !== 1'b1 || ack1 !== 1'b0 || thr_load !== 1'b1 || thr_d !== 8'hA5 || thr_full !== 1'b0) begin
      bad++; $display("FAIL single_grant got=%b%b%b%b/%h exp=1010/a5", ack0, ack1, thr_load, thr_full, thr_d);
    end
    req0 = 1'b0;
    tick();
    total++;
    if (ack0 !== 1'b0 || thr_load !== 1'b0 || thr_full !== 1'b1 || thr_d !== 8'hA5 || tsr_load !== 1'b0) begin
      bad++; $display("FAIL single_loaded got=%b%b%b%b/%h exp=0010/a5", ack0, thr_load, thr_full, tsr_load, thr_d);
    end
    tx_rdy = 1'b1;
    tick();
    total++;
    if (tsr_load !== 1'b1 || thr_full !== 1'b1) begin
      bad++; $display("FAIL single_xfer got=%b%b exp=11", tsr_load, thr_full);
    end
    // tx_rdy dropping during XFER must not abort the transfer
    tx_rdy = 1'b0;
    tick();
    total++;
    if (tsr_load !== 1'b0 || thr_full !== 1'b0 || xfer_cnt !== 8'h01) begin
      bad++; $display("FAIL single_done got=%b%b/%h exp=00/01", tsr_load, thr_full, xfer_cnt);
    end
  endtask

  task automatic test_contention();
    logic [7:0] exp_d;
    logic       got;
    int         waited;
    do_reset();
    req0 = 1'b1; req1 = 1'b1; d0 = 8'h11; d1 = 8'h22; tx_rdy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      got = 1'b0; waited = 0;
      for (int c = 0; c < 8 && !got; c++) begin
        tick();
        waited++;
        if (ack0 || ack1) got = 1'b1;
      end
      total++;
      if (!got) begin
        bad++; $display("FAIL contention_timeout grant=%0d got=none exp=ack", k);
        break;
      end
      exp_d = (k % 2 == 0) ? 8'h11 : 8'h22;
      total++;
      if (ack0 !== (k % 2 == 0) || ack1 !== (k % 2 == 1) || thr_d !== exp_d || thr_load !== 1'b1 || tsr_load !== 1'b0) begin
        bad++; $display("FAIL contention_grant%0d got=%b%b%b%b/%h exp=%b%b10/%h",
                        k, ack0, ack1, thr_load, tsr_load, thr_d, (k % 2 == 0), (k % 2 == 1), exp_d);
      end
      total++;
      if (waited !== ((k == 0) ? 1 : 4)) begin
        bad++; $display("FAIL contention_spacing%0d got=%0d exp=%0d", k, waited, (k == 0) ? 1 : 4);
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    tick(); tick(); tick();
    tx_rdy = 1'b0;
    total++;
    if (xfer_cnt !== 8'h04 || thr_full !== 1'b0) begin
      bad++; $display("FAIL contention_cnt got=%h/%b exp=04/0", xfer_cnt, thr_full);
    end
  endtask

  task automatic test_stall();
    int stall_errs;
    // rr_ptr now points at port 0 after the last contention grant went to port 1
    req0 = 1'b1; d0 = 8'h77;
    tick();
    total++;
    if (ack0 !== 1'b1 || thr_d !== 8'h77) begin
      bad++; $display("FAIL stall_first got=%b/%h exp=1/77", ack0, thr_d);
    end
    req0 = 1'b0; req1 = 1'b1; d1 = 8'h99;
    tick();
    stall_errs = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (ack1 !== 1'b0 || thr_load !== 1'b0 || thr_full !== 1'b1 || tsr_load !== 1'b0) stall_errs++;
    end
    total++;
    if (stall_errs != 0) begin
      bad++; $display("FAIL stall_hold got=%0d bad cycles exp=0", stall_errs);
    end
    tx_rdy = 1'b1;
    tick();
    tx_rdy = 1'b0;
    total++;
    if (tsr_load !== 1'b1 || ack1 !== 1'b0) begin
      bad++; $display("FAIL stall_xfer got=%b%b exp=10", tsr_load, ack1);
    end
    tick();
    total++;
    if (ack1 !== 1'b0 || thr_full !== 1'b0) begin
      bad++; $display("FAIL stall_empty got=%b%b exp=00", ack1, thr_full);
    end
    tick();
    total++;
    if (ack1 !== 1'b1 || thr_load !== 1'b1 || thr_d !== 8'h99) begin
      bad++; $display("FAIL stall_ack1 got=%b%b/%h exp=11/99", ack1, thr_load, thr_d);
    end
    req1 = 1'b0; tx_rdy = 1'b1;
    tick(); tick(); tick();
    tx_rdy = 1'b0;
    total++;
    if (xfer_cnt !== 8'h06) begin
      bad++; $display("FAIL stall_cnt got=%h exp=06", xfer_cnt);
    end
  endtask

  task automatic test_wrap();
    int nload, ntsr;
    do_reset();
    nload = 0; ntsr = 0;
    req0 = 1'b1; d0 = 8'h5E; tx_rdy = 1'b1;
    for (int c = 0; c < 1100 && nload < 256; c++) begin
      tick();
      if (thr_load) nload++;
      if (tsr_load) ntsr++;
    end
    total++;
    if (nload != 256) begin
      bad++; $display("FAIL wrap_loads got=%0d exp=256", nload);
    end
    total++;
    if (xfer_cnt !== 8'hFF) begin
      bad++; $display("FAIL wrap_allones got=%h exp=ff", xfer_cnt);
    end
    req0 = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (tsr_load) ntsr++;
    end
    tx_rdy = 1'b0;
    total++;
    if (xfer_cnt !== 8'h00) begin
      bad++; $display("FAIL wrap_cnt got=%h exp=00", xfer_cnt);
    end
    total++;
    if (ntsr != nload) begin
      bad++; $display("FAIL wrap_balance got=%0d tsr exp=%0d", ntsr, nload);
    end
  endtask

  task automatic test_reset_xfer();
    int spurious;
    req1 = 1'b1; d1 = 8'hC3;
    tick();
    req1 = 1'b0; tx_rdy = 1'b1;
    tick(); tick();
    total++;
    if (tsr_load !== 1'b1 || xfer_cnt !== 8'h00) begin
      bad++; $display("FAIL rstx_pre got=%b/%h exp=1/00", tsr_load, xfer_cnt);
    end
    // count now at 0 after the wrap; one more full transfer gives a nonzero value to clear
    tick();
    tx_rdy = 1'b0;
    req0 = 1'b1; d0 = 8'h0F;
    tick();
    req0 = 1'b0; tx_rdy = 1'b1;
    tick(); tick();
    total++;
    if (tsr_load !== 1'b1 || xfer_cnt !== 8'h01) begin
      bad++; $display("FAIL rstx_xfer got=%b/%h exp=1/01", tsr_load, xfer_cnt);
    end
    #1 rst = 1'b1;
    #1;
    total++;
    if (tsr_load !== 1'b0 || xfer_cnt !== 8'h00 || thr_full !== 1'b0) begin
      bad++; $display("FAIL rstx_async got=%b%b/%h exp=00/00", tsr_load, thr_full, xfer_cnt);
    end
    tx_rdy = 1'b0;
    tick();
    rst = 1'b0;
    spurious = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (ack0 || ack1 || thr_load || tsr_load) spurious++;
    end
    total++;
    if (spurious != 0 || xfer_cnt !== 8'h00) begin
      bad++; $display("FAIL rstx_after got=%0d/%h exp=0/00", spurious, xfer_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_stall();
    test_wrap();
    test_reset_xfer();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
